fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of fifo_buffer among N_REQ producers.
//  Per cycle: grants at most one requester (valid/ready style), registers its word and
//  drives the fifo write strobe/data. Honours full/almost-full so no write is ever dropped.
//  Sits between producer PEs and the fifo write side; also keeps a wrapping write counter.
// PARAMETERS
//  DATA_WIDTH  8   width of each data word
//  N_REQ       4   number of requesters (>=2)
//  CNT_WIDTH   16  width of wr_count
//  BURST_LEN   4   max consecutive transfers per grant (used only with FIFO_ARB_BURST_EN)
// PORTS
//  clk              in   1                   clock, rising edge
//  rst              in   1                   asynchronous, active-high reset
//  req              in   N_REQ               req[i]=1: requester i has a valid word
//  req_data         in   DATA_WIDTH x N_REQ  unpacked array, word of requester i
//  grant            out  N_REQ               combinational one-hot; transfer when req[i]&grant[i]
//  fifo_full        in   1                   fifo full flag
//  fifo_almost_full in   1                   fifo has exactly one free slot
//  fifo_wr_en       out  1                   registered write strobe to fifo
//  fifo_wr_data     out  DATA_WIDTH          registered write data
//  busy             out  1                   state != IDLE
//  wr_count         out  CNT_WIDTH           total accepted transfers, wraps
// BEHAVIOUR
//  - Reset (async, rst=1): grant=0, fifo_wr_en=0, fifo_wr_data=0, wr_count=0, busy=0,
//    state=IDLE, priority pointer=N_REQ-1 (so requester 0 wins first).
//  - blocked = fifo_full | (fifo_wr_en & fifo_almost_full)  (covers in-flight write).
//  - grant: if !blocked and |req, one-hot on first req[i] set scanning ptr+1, ptr+2, ...
//    (mod N_REQ); else 0. grant never set for a requester with req=0.
//  - Transfer at posedge when |(req&grant): fifo_wr_en<=1, fifo_wr_data<=req_data[idx],
//    ptr<=idx, wr_count<=wr_count+1 (mod 2^CNT_WIDTH). Else fifo_wr_en<=0, data holds.
//  - Latency: requester word appears on fifo_wr_data/fifo_wr_en 1 cycle after acceptance.
//    Throughput: 1 word/cycle while not blocked.
//  - FSM (state registered):
//      IDLE : req==0.                 -> SERVE if |req & !blocked; -> STALL if |req & blocked
//      SERVE: granting this cycle.    -> IDLE if req==0; -> STALL if blocked
//      STALL: |req & blocked, grant=0 -> SERVE when !blocked; -> IDLE if req drops to 0
//    busy=1 in SERVE and STALL.
//  - Requester may drop req without a grant; no state is kept for it beyond the pointer.
//  - Simultaneous requests: strict round-robin; no requester waits more than N_REQ-1
//    transfers while its req stays high.
//  - fifo_full rising while fifo_wr_en=1 is legal (write already accounted by almost_full).
//  - rst mid-transfer: pending fifo_wr_en cleared immediately; the word is lost
//    (producer must re-send); pointer returns to N_REQ-1.
// CONFIGURATION
//  FIFO_ARB_BURST_EN defined: after a grant to idx, the pointer is frozen and idx keeps
//    priority for up to BURST_LEN consecutive transfers while req[idx]=1 and !blocked
//    (a blocked cycle pauses the burst but does not end it). Burst ends on req[idx]=0 or
//    count==BURST_LEN; then normal round-robin resumes from idx+1. Internal burst counter
//    resets to 0 on rst and at every burst end.
//  Undefined: pointer advances after every transfer (burst length effectively 1); no
//    burst counter is instantiated.
// TESTING
//  1 Reset: rst=1 mid-run with fifo_wr_en=1 -> all outputs 0 same cycle, wr_count=0.
//  2 req=4'b1111, fifo never full, no burst -> accepted order 0,1,2,3,0,...;
//    wr_count=8 after 8 cycles; fifo_wr_data matches the grant one cycle earlier.
//  3 req=4'b0100 alone, data 8'hA5 -> grant=4'b0100 every cycle, fifo_wr_en=1 continuous.
//  4 fifo_almost_full=1 with fifo_wr_en=1 -> grant=0, state STALL, busy=1; release ->
//    SERVE next cycle, no word lost or duplicated (scoreboard vs fifo contents).
//  5 FIFO_ARB_BURST_EN, BURST_LEN=4, req=4'b0011 -> order 0,0,0,0,1,1,1,1,0...;
//    req[0] dropped after 2 -> switch to 1 immediately.
//  6 CNT_WIDTH=4, 17 transfers -> wr_count=1 (wrap).

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Purpose: producer/fifo-side bundle for fifo_write_arbiter (requests, grants, fifo write port).
// Latency: none, wires only.
// Backpressure: carried by grant (per requester) and fifo_full/fifo_almost_full (from the fifo).
interface fifo_write_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int CNT_WIDTH  = 16
);
  logic [N_REQ-1:0]      req;
  logic [DATA_WIDTH-1:0] req_data [N_REQ];
  logic [N_REQ-1:0]      grant;
  logic                  fifo_full;
  logic                  fifo_almost_full;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  wr_count;

  // Environment side: producers plus the fifo status flags.
  modport master (
    output req, req_data, fifo_full, fifo_almost_full,
    input  grant, fifo_wr_en, fifo_wr_data, busy, wr_count
  );

  // Arbiter side.
  modport slave (
    input  req, req_data, fifo_full, fifo_almost_full,
    output grant, fifo_wr_en, fifo_wr_data, busy, wr_count
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Purpose: round-robin sharing of the single fifo write port among N_REQ producers, plus a wrapping write counter.
// Latency: accepted word shows on fifo_wr_data/fifo_wr_en one cycle after its grant; one word per cycle.
// Backpressure: grant is withheld while the fifo is full or its last free slot is taken by the in-flight write.
// Option: define FIFO_ARB_BURST_EN to let a grantee keep priority for up to BURST_LEN consecutive transfers.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                clk,
  input  logic                rst,
  fifo_write_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2
  } state_t;

  // Elaboration-time sanity checks on the configuration.
  generate
    if (N_REQ < 2) begin : g_bad_nreq
      $error("fifo_write_arbiter: N_REQ must be at least 2");
    end
    if (BURST_LEN < 1) begin : g_bad_burst
      $error("fifo_write_arbiter: BURST_LEN must be at least 1");
    end
  endgenerate

  state_t                state_q;
  state_t                state_d;

  logic [PW-1:0]         ptr;        // last granted requester; scan starts just after it
  logic [PW-1:0]         win_idx;
  logic                  win_vld;
  logic [PW:0]           cand;       // one extra bit so ptr+k never overflows before the wrap
  logic                  blocked;
  logic                  any_req;
  logic                  xfer;
  logic                  burst_hold;
  logic [N_REQ-1:0]      grant_w;

  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [CNT_WIDTH-1:0]  wr_count_q;

  // A write already in flight consumes the last free slot, so almost-full blocks only while wr_en is up.
  assign blocked = bus.fifo_full | (wr_en_q & bus.fifo_almost_full);
  assign any_req = |bus.req;

`ifdef FIFO_ARB_BURST_EN
  localparam int BCW = $clog2(BURST_LEN + 1);

  logic [BCW-1:0] burst_cnt;  // transfers so far in the running burst of requester ptr; 0 = no burst
  logic [BCW-1:0] burst_nxt;

  // The burst owner keeps priority only while it is still requesting.
  assign burst_hold = (burst_cnt != '0) & bus.req[ptr];
  assign burst_nxt  = (burst_hold ? burst_cnt : '0) + BCW'(1);

  // Burst length tracking: count transfers of the owner, close the burst at BURST_LEN or when it drops req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (xfer) begin
      burst_cnt <= (burst_nxt == BCW'(BURST_LEN)) ? '0 : burst_nxt;
    end else if ((burst_cnt != '0) && !bus.req[ptr]) begin
      burst_cnt <= '0;
    end
  end
`else
  assign burst_hold = 1'b0;
`endif

  // Round-robin pick: scan from ptr+N down to ptr+1 so the nearest requester after ptr is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_REQ)) begin
        cand = cand - (PW+1)'(N_REQ);
      end
      if (bus.req[cand[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
    if (burst_hold) begin
      win_vld = 1'b1;
      win_idx = ptr;
    end
  end

  // One-hot grant, suppressed while blocked or in reset.
  always_comb begin
    grant_w = '0;
    if (!rst && !blocked && win_vld) begin
      grant_w = N_REQ'(1) << win_idx;
    end
  end

  assign xfer = |(bus.req & grant_w);

  // Datapath: register the accepted word, advance the pointer and the write counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
      ptr        <= PTR_RST;
    end else if (xfer) begin
      wr_en_q    <= 1'b1;
      wr_data_q  <= bus.req_data[win_idx];
      wr_count_q <= wr_count_q + CNT_WIDTH'(1);
      ptr        <= win_idx;
    end else begin
      wr_en_q    <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: idle without requests, otherwise serve or stall on fifo backpressure.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = blocked ? STALL : SERVE;
        end
      end
      SERVE: begin
        if (!any_req) begin
          state_d = IDLE;
        end else if (blocked) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (!any_req) begin
          state_d = IDLE;
        end else if (!blocked) begin
          state_d = SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.busy = 1'b0;
    if (state_q != IDLE) begin
      bus.busy = 1'b1;
    end
  end

  assign bus.grant        = grant_w;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.wr_count     = wr_count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Purpose: randomized bench for fifo_write_arbiter against a queue-based arbitration and fifo model.
// Latency: expects each granted word on fifo_wr_data one cycle later.
// Backpressure: a depth-4 fifo model with random draining produces the full/almost-full flags.
module tb_fifo_write_arbiter;

  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int CW    = 4;
  localparam int BL    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  fifo_write_arbiter_if #(.DATA_WIDTH(DW), .N_REQ(N), .CNT_WIDTH(CW)) bus ();

  fifo_write_arbiter #(
    .DATA_WIDTH(DW), .N_REQ(N), .CNT_WIDTH(CW), .BURST_LEN(BL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: last served requester, pending output word, totals.
  int              last      = N - 1;
  bit              exp_wr_en = 1'b0;
  logic [DW-1:0]   exp_data  = '0;
  int              exp_cnt   = 0;
  bit              exp_busy  = 1'b0;
  int              b_cnt     = 0;
  logic [DW-1:0]   acc_q [$];   // accepted words, oldest first
  logic [DW-1:0]   fq [$];      // contents of the modelled fifo
  bit              cur_wr_en;
  logic [DW-1:0]   cur_wr_data;
  bit              pop_now;
  logic [N-1:0]    obs_grant;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Requester that should win now, or -1.
  function automatic int pick();
    if (rst) return -1;
    if (bus.fifo_full || (exp_wr_en && bus.fifo_almost_full)) return -1;
`ifdef FIFO_ARB_BURST_EN
    if (b_cnt > 0 && bus.req[last]) return last;
`endif
    for (int k = 1; k <= N; k++) begin
      if (bus.req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_wr_en",   bus.fifo_wr_en,   0);
    chk("rst_wr_data", bus.fifo_wr_data, 0);
    chk("rst_count",   bus.wr_count,     0);
    chk("rst_busy",    bus.busy,         0);
    chk("rst_grant",   bus.grant,        0);
    if (exp_wr_en) void'(acc_q.pop_back());  // in-flight word is lost
    last      = N - 1;
    exp_wr_en = 1'b0;
    exp_data  = '0;
    exp_cnt   = 0;
    exp_busy  = 1'b0;
    b_cnt     = 0;
    #2 rst = 1'b0;
  endtask

  task automatic cycle(input logic [N-1:0] r, input int pop_pct,
                       input bit use_fix, input logic [DW-1:0] fix);
    int           idx;
    logic [N-1:0] eg;
    @(negedge clk);
    bus.req = r;
    for (int i = 0; i < N; i++) bus.req_data[i] = use_fix ? fix : DW'($urandom);
    bus.fifo_full        = (fq.size() == DEPTH);
    bus.fifo_almost_full = (fq.size() == DEPTH - 1);
    cur_wr_en   = bus.fifo_wr_en;
    cur_wr_data = bus.fifo_wr_data;
    pop_now     = (fq.size() > 0) && (int'($urandom_range(99)) < pop_pct);
    #1;
    idx = pick();
    eg  = (idx >= 0) ? (N'(1) << idx) : '0;
    obs_grant = bus.grant;
    chk("grant", bus.grant, eg);

    @(posedge clk);
    if (cur_wr_en) chk("no_overflow", (fq.size() < DEPTH), 1);
    if (pop_now) begin
      if (acc_q.size() == 0) chk("fifo_extra_word", 1, 0);
      else chk("fifo_order", fq.pop_front(), acc_q.pop_front());
    end
    if (cur_wr_en && fq.size() < DEPTH) fq.push_back(cur_wr_data);

    if (idx >= 0) begin
      acc_q.push_back(bus.req_data[idx]);
      exp_data  = bus.req_data[idx];
      exp_wr_en = 1'b1;
      exp_cnt   = (exp_cnt + 1) % (1 << CW);
`ifdef FIFO_ARB_BURST_EN
      if (b_cnt > 0 && idx == last) b_cnt++;
      else b_cnt = 1;
      if (b_cnt == BL) b_cnt = 0;
`endif
      last = idx;
    end else begin
      exp_wr_en = 1'b0;
`ifdef FIFO_ARB_BURST_EN
      if (b_cnt > 0 && !r[last]) b_cnt = 0;
`endif
    end
    exp_busy = (r != '0);

    #1;
    chk("wr_en",    bus.fifo_wr_en,   exp_wr_en);
    chk("wr_data",  bus.fifo_wr_data, exp_data);
    chk("wr_count", bus.wr_count,     exp_cnt);
    chk("busy",     bus.busy,         exp_busy);
  endtask

  initial begin
    int pp;
    bus.req              = '0;
    bus.fifo_full        = 1'b0;
    bus.fifo_almost_full = 1'b0;
    for (int i = 0; i < N; i++) bus.req_data[i] = '0;
    rst = 1'b0;
    #1 do_reset();

    // All four requesting, fifo drained every cycle.
    for (int c = 0; c < 8; c++) begin
      cycle(4'b1111, 100, 1'b0, '0);
`ifdef FIFO_ARB_BURST_EN
      chk("rr_order", obs_grant, N'(1) << ((c / BL) % N));
`else
      chk("rr_order", obs_grant, N'(1) << (c % N));
`endif
    end
    chk("count_after_8", bus.wr_count, 8);

    // Single requester streaming a fixed word.
    for (int c = 0; c < 6; c++) begin
      cycle(4'b0100, 100, 1'b1, 8'hA5);
      chk("single_grant", obs_grant, 4'b0100);
      chk("single_wr_en", bus.fifo_wr_en, 1);
      chk("single_data",  bus.fifo_wr_data, 8'hA5);
    end

    // Stop draining until the fifo fills, then release.
    for (int c = 0; c < 8; c++) cycle(4'b1111, 0, 1'b0, '0);
    chk("stall_grant", obs_grant, 0);
    chk("stall_busy",  bus.busy,  1);
    for (int c = 0; c < 8; c++) cycle(4'b1111, 100, 1'b0, '0);

    // Reset while a write is in flight.
    for (int c = 0; c < 6; c++) cycle(4'b0000, 100, 1'b0, '0);
    for (int c = 0; c < 3; c++) cycle(4'b1111, 100, 1'b0, '0);
    chk("pre_rst_wr_en", bus.fifo_wr_en, 1);
    do_reset();

    // Two requesters from a fresh pointer.
    for (int c = 0; c < 8; c++) begin
      cycle(4'b0011, 100, 1'b0, '0);
`ifdef FIFO_ARB_BURST_EN
      chk("pair_order", obs_grant, N'(1) << ((c / BL) % 2));
`else
      chk("pair_order", obs_grant, N'(1) << (c % 2));
`endif
    end

    // Random requests under random fifo pressure.
    for (int w = 0; w < 20; w++) begin
      pp = int'($urandom_range(100));
      for (int c = 0; c < 20; c++) cycle(N'($urandom), pp, 1'b0, '0);
    end

    // Counter wrap: 17 transfers into a 4-bit counter.
    for (int c = 0; c < 6; c++) cycle(4'b0000, 100, 1'b0, '0);
    do_reset();
    for (int c = 0; c < 17; c++) cycle(4'b0001, 100, 1'b0, '0);
    chk("count_wrap", bus.wr_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
